// File: rtl/exec_pkg.sv
// Shared definitions for the exec_sequencer slice.
// Contents: the instruction field bit positions, the opcode values, the
// sequencer state encoding, and small opcode classification helpers that
// the top level and the ALU share.
package exec_pkg;

  // Instruction field bit positions
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RC_HI  = 11;
  localparam int RC_LO  = 9;
  localparam int RA_HI  = 8;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcode values
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_LDI  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Ops that write the destination register (ADD..LDI)
  function automatic logic op_writes_rf(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

  // Ops that update Z/C (ADD..SHR)
  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  // Opcodes above HALT are undefined
  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_HALT;
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational ALU for the exec_sequencer.
// Ports:
//   op     : opcode (exec_pkg OP_* values)
//   a, b   : operands (b carries the immediate for LDI)
//   result : W-bit result
//   carry  : carry for ADD, borrow for SUB, shifted-out bit for SHL/SHR
//   zero   : result == 0
module alu8
  import exec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // The top bit of the extended difference is the borrow, i.e. a < b.
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
      end
      OP_SUB: begin
        result = diff[W-1:0];
        carry  = diff[W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[W-2:0], 1'b0};
        carry  = a[W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[W-1:1]};
        carry  = a[0];
      end
      OP_LDI: result = b;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction at a time,
// walks it through DECODE, EXEC and WB against an external register file,
// and keeps zero/carry flags.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   instr_valid/instr_ready  : instruction handshake (ready only in IDLE)
//   instr                    : [15:12] op, [11:9] rc, [8:6] ra, [5:3] rb, [7:0] imm8
//   rf_raddr1/2, rf_rdata1/2 : register file read ports (combinational data)
//   rf_waddr/wdata/we        : register file write port, active in WB only
//   flag_z, flag_c           : zero and carry flags
//   done, illegal            : retire pulse, undefined-opcode pulse
//   halted                   : sticky after HALT retires
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  rf_raddr1,
  output logic [ADDR_W-1:0]  rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  output logic [ADDR_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               rf_we,
  output logic               flag_z,
  output logic               flag_c,
  output logic               done,
  output logic               illegal,
  output logic               halted
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_c_q, flag_c_d;

  logic [3:0]         op;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_carry;
  logic               alu_zero;

  assign op  = instr_q[OP_HI:OP_LO];
  assign imm = DATA_W'(instr_q[IMM_HI:IMM_LO]);

  // Read addresses come straight from the held instruction so they are
  // stable through DECODE and EXEC, and zero while in reset.
  assign rf_raddr1 = ADDR_W'(instr_q[RA_HI:RA_LO]);
  assign rf_raddr2 = ADDR_W'(instr_q[RB_HI:RB_LO]);
  assign rf_waddr  = ADDR_W'(instr_q[RC_HI:RC_LO]);
  assign rf_wdata  = result_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign halted    = (state_q == ST_HALT);

  // LDI reuses the ALU pass-through path with the immediate on operand b.
  assign alu_b = (op == OP_LDI) ? imm : rf_rdata2;

  alu8 #(.W(DATA_W)) u_alu (
    .op     (op),
    .a      (rf_rdata1),
    .b      (alu_b),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    result_d    = result_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        // Operands are captured here, before WB, so rc aliasing ra/rb
        // always sees the pre-write values.
        result_d = alu_result;
        if (op_sets_flags(op)) begin
          flag_z_d = alu_zero;
          flag_c_d = alu_carry;
        end
        state_d = ST_WB;
      end
      ST_WB: begin
        done    = 1'b1;
        illegal = op_is_illegal(op);
        rf_we   = op_writes_rf(op);
        state_d = (op == OP_HALT) ? ST_HALT : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [7:0]  rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we, flag_z, flag_c, done, illegal, halted;

  int total = 0;
  int bad   = 0;

  logic [7:0] regs [8] = '{default: 8'h00};

  always #5 clk = ~clk;

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];
  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;

  exec_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_we      (rf_we),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .done       (done),
    .illegal    (illegal),
    .halted     (halted)
  );

  typedef struct {
    logic [15:0] instr;
    logic        we;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic        z;
    logic        c;
    logic        ill;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},      rf_we, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_illegal"}, illegal, 0);
    check({tag, "_halted"},  halted, 0);
    check({tag, "_z"},       flag_z, 0);
    check({tag, "_c"},       flag_c, 0);
    check({tag, "_raddr1"},  rf_raddr1, 0);
    check({tag, "_raddr2"},  rf_raddr2, 0);
    check({tag, "_waddr"},   rf_waddr, 0);
    check({tag, "_wdata"},   rf_wdata, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", instr_ready, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    wait_ready();
    @(negedge clk);
    instr = v.instr;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'hA5A5;
    check({s, "_decode_done"}, done, 0);
    check({s, "_decode_ready"}, instr_ready, 0);
    @(posedge clk); #1;
    check({s, "_exec_done"}, done, 0);
    check({s, "_exec_we"}, rf_we, 0);
    @(posedge clk); #1;
    check({s, "_wb_done"}, done, 1);
    check({s, "_wb_we"}, rf_we, v.we);
    check({s, "_wb_illegal"}, illegal, v.ill);
    check({s, "_wb_z"}, flag_z, v.z);
    check({s, "_wb_c"}, flag_c, v.c);
    if (v.we) begin
      check({s, "_wb_waddr"}, rf_waddr, v.waddr);
      check({s, "_wb_wdata"}, rf_wdata, v.wdata);
    end
    @(posedge clk); #1;
    check({s, "_after_ready"}, instr_ready, 1);
    check({s, "_after_done"}, done, 0);
    check({s, "_after_we"}, rf_we, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cont [4];
    logic        hs;
    int          hs_cnt, last_hs, writes;

    //              instr     we waddr wdata  z  c  ill
    vecs[0]  = '{16'h82F0, 1, 3'd1, 8'hF0, 0, 0, 0}; // LDI r1,F0
    vecs[1]  = '{16'h8420, 1, 3'd2, 8'h20, 0, 0, 0}; // LDI r2,20
    vecs[2]  = '{16'h1650, 1, 3'd3, 8'h10, 0, 1, 0}; // ADD r3,r1,r2
    vecs[3]  = '{16'h2890, 1, 3'd4, 8'h00, 1, 0, 0}; // SUB r4,r2,r2
    vecs[4]  = '{16'h2AD0, 1, 3'd5, 8'hF0, 0, 1, 0}; // SUB r5,r3,r2
    vecs[5]  = '{16'hC000, 0, 3'd0, 8'h00, 0, 1, 1}; // illegal 0xC
    vecs[6]  = '{16'h3C68, 1, 3'd6, 8'hF0, 0, 0, 0}; // AND r6,r1,r5
    vecs[7]  = '{16'h5E68, 1, 3'd7, 8'h00, 1, 0, 0}; // XOR r7,r1,r5
    vecs[8]  = '{16'h4DD0, 1, 3'd6, 8'h20, 0, 0, 0}; // OR r6,r7,r2
    vecs[9]  = '{16'h6C40, 1, 3'd6, 8'hE0, 0, 1, 0}; // SHL r6,r1
    vecs[10] = '{16'h7C80, 1, 3'd6, 8'h10, 0, 0, 0}; // SHR r6,r2
    vecs[11] = '{16'h8001, 1, 3'd0, 8'h01, 0, 0, 0}; // LDI r0,01
    vecs[12] = '{16'h7000, 1, 3'd0, 8'h00, 1, 1, 0}; // SHR r0,r0
    vecs[13] = '{16'h1248, 1, 3'd1, 8'hE0, 0, 1, 0}; // ADD r1,r1,r1
    vecs[14] = '{16'h0000, 0, 3'd0, 8'h00, 0, 1, 0}; // NOP
    vecs[15] = '{16'h1450, 1, 3'd2, 8'h00, 1, 1, 0}; // ADD r2,r1,r2

    rst_n = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("por_ready", instr_ready, 1);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Back-to-back: valid held high, one handshake every 4 cycles.
    for (int k = 0; k < 4; k++) cont[k] = 16'h8000 | 16'((k + 1) << 9) | 16'(8'h31 + k);
    wait_ready();
    @(negedge clk);
    instr_valid = 1'b1;
    instr = cont[0];
    hs_cnt = 0;
    last_hs = -1;
    writes = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      hs = instr_ready && instr_valid;
      @(posedge clk); #1;
      if (rf_we) begin
        check("cont_wdata", rf_wdata, 32'h31 + writes);
        check("cont_waddr", rf_waddr, 32'(writes + 1));
        writes++;
      end
      if (hs) begin
        if (hs_cnt > 0) check("cont_interval", cyc - last_hs, 4);
        last_hs = cyc;
        hs_cnt++;
      end
      @(negedge clk);
      if (hs) begin
        if (hs_cnt < 4) instr = cont[hs_cnt];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    check("cont_handshakes", hs_cnt, 4);
    check("cont_writes", writes, 4);

    // Reset while an ADD is in EXEC: aborted, no write, outputs cleared.
    wait_ready();
    @(negedge clk);
    instr = 16'h1650;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_hold_we", rf_we, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort_ready", instr_ready, 1);
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_post_we", rf_we, 0);
      check("abort_post_done", done, 0);
    end
    check("abort_r3_kept", regs[3], 8'h33);

    // HALT is sticky and ignores further instructions until reset.
    wait_ready();
    @(negedge clk);
    instr = 16'h9000;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("halt_wb_done", done, 1);
    check("halt_wb_we", rf_we, 0);
    check("halt_wb_illegal", illegal, 0);
    @(negedge clk);
    instr = 16'h8255;
    instr_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("halt_halted", halted, 1);
      check("halt_ready", instr_ready, 0);
      check("halt_we", rf_we, 0);
      check("halt_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("halt_rst_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("halt_rel_ready", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("halt_resume_we", rf_we, 1);
    check("halt_resume_wdata", rf_wdata, 8'h55);
    check("halt_resume_waddr", rf_waddr, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
